// File: rtl/fb_write_arbiter.sv
// Frame buffer write port: round-robin merge of two pixel requesters plus a full-buffer clear sweep.
// One-cycle registered write latency; ready is combinational, and both readys are low while clearing.
module fb_write_arbiter #(
  parameter int                    ADDR_WIDTH  = 19,
  parameter int                    DATA_WIDTH  = 3,
  parameter logic [ADDR_WIDTH-1:0] MAX_ADDR    = ADDR_WIDTH'(307199),
  parameter logic [DATA_WIDTH-1:0] CLEAR_COLOR = '1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  clear_done,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  addr_err
);

  typedef enum logic {IDLE, CLEAR} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } pix_t;

  state_t                state;
  logic                  last_grant;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  can_grant;
  logic                  contend;
  logic                  gnt0;
  logic                  gnt1;
  pix_t                  beat;

  // A clear request in IDLE pre-empts any grant in the same cycle.
  assign can_grant = (state == IDLE) && !clear_req;
  assign contend   = req0_valid && req1_valid;
  assign gnt0      = can_grant && req0_valid && (!req1_valid || last_grant);
  assign gnt1      = can_grant && req1_valid && (!req0_valid || !last_grant);
  assign beat      = gnt0 ? pix_t'{req0_addr, req0_data} : pix_t'{req1_addr, req1_data};

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      clr_cnt    <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      ram_we     <= 1'b0;
      clear_done <= 1'b0;
      addr_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            // First sweep write issues straight away; clr_cnt tracks the address on the bus.
            state      <= CLEAR;
            clear_busy <= 1'b1;
            clr_cnt    <= '0;
            ram_we     <= 1'b1;
            ram_addr   <= '0;
            ram_din    <= CLEAR_COLOR;
          end else if (gnt0 || gnt1) begin
            if (contend) last_grant <= gnt1;
            if (beat.addr > MAX_ADDR) begin
              addr_err <= 1'b1;
            end else begin
              ram_we   <= 1'b1;
              ram_addr <= beat.addr;
              ram_din  <= beat.data;
            end
          end
        end
        CLEAR: begin
          if (clr_cnt == MAX_ADDR) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
            clr_cnt    <= '0;
          end else begin
            clr_cnt  <= clr_cnt + 1'b1;
            ram_we   <= 1'b1;
            ram_addr <= clr_cnt + 1'b1;
            ram_din  <= CLEAR_COLOR;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Single write-port controller for the 640x480 3-bit frame buffer RAM.
- Merges two drawing requesters (board/piece renderer and cursor renderer) onto the RAM write port A with round-robin arbitration.
- Provides a hardware clear sweep that fills the whole buffer with a background colour.
- Drives the RAM's `we`/`addr_a`/`din_a`. The RAM's own reset-clear path is unused, with `reset_ram` tied low.

Parameters:
- ADDR_WIDTH, 19, frame buffer address width.
- DATA_WIDTH, 3, pixel colour width.
- MAX_ADDR, 307199, last valid pixel address (640*480-1).
- CLEAR_COLOR, 3'b111, colour written by the clear sweep.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear_req  in  1  single-cycle pulse: start a full-buffer clear.
- clear_busy  out  1  high while the sweep runs.
- clear_done  out  1  one-cycle pulse after the last clear write.
- req0_valid  in  1  requester 0 has a pixel write.
- req0_addr  in  ADDR_WIDTH  requester 0 pixel address.
- req0_data  in  DATA_WIDTH  requester 0 colour.
- req0_ready  out  1  requester 0 beat accepted this cycle (combinational).
- req1_valid, req1_addr, req1_data, req1_ready: same as requester 0, for requester 1.
- ram_we  out  1  RAM write enable (registered).
- ram_addr  out  ADDR_WIDTH  RAM write address (registered).
- ram_din  out  DATA_WIDTH  RAM write data (registered).
- addr_err  out  1  one-cycle pulse: an accepted beat had addr > MAX_ADDR and was dropped.

Behaviour:
- Reset (rst_n=0, async):
  - ram_we, ram_addr, ram_din, clear_busy, clear_done and addr_err all go to 0.
  - State goes to IDLE, clear counter to 0, last_grant to 1 (so requester 0 wins first).
  - Reset mid-sweep aborts the sweep. No clear_done is generated.
- Transfer rule: a beat transfers when reqX_valid and reqX_ready are both high on a rising edge. A requester must hold addr/data stable while valid is high and ready is low.
- States: IDLE and CLEAR.
- IDLE:
  - If clear_req=1: the next state is CLEAR, both readys are 0 this cycle and no grant is made. Clear wins over any simultaneous requests.
  - Otherwise, with only one valid: that requester gets ready=1.
  - With both valid: the requester that is not last_grant gets ready=1, and last_grant updates to the winner.
  - At most one ready is high in any cycle.
  - Accepted beat in cycle N: ram_we=1 with that beat's addr/data in cycle N+1.
  - If addr > MAX_ADDR: ram_we=0 in N+1 and addr_err=1 in N+1. The beat is still consumed.
  - No accepted beat: ram_we=0; ram_addr and ram_din hold their previous values.
- CLEAR:
  - clear_busy=1 and both readys are 0.
  - Each cycle: ram_we=1, ram_addr=counter, ram_din=CLEAR_COLOR, then counter increments.
  - Counter runs 0 to MAX_ADDR with no wrap. The sweep takes exactly MAX_ADDR+1 write cycles.
  - In the cycle after the MAX_ADDR write: clear_done=1, clear_busy=0, ram_we=0, state returns to IDLE, counter resets to 0. Requests may be granted in that same cycle.
  - clear_req during CLEAR is ignored; it does not restart or extend the sweep.
- Throughput: one write per cycle maximum. Round-robin guarantees each requester a grant at least every second cycle under contention.
- Width: counter is ADDR_WIDTH bits; the comparison against MAX_ADDR is unsigned.

Test Plan (bench uses MAX_ADDR=15):
- Reset, then req0 alone writes addr 5 data 3'b010 → req0_ready=1 same cycle; next cycle ram_we=1, ram_addr=5, ram_din=3'b010.
- req0 and req1 both continuously valid for 6 cycles → grants alternate 0,1,0,1,0,1 (req0 first); 6 RAM writes, each with the correct addr/data.
- clear_req pulse while req1_valid=1 → no grant that cycle; clear_busy high 16 cycles with ram_addr 0..15 and ram_din=3'b111; clear_done pulse after addr 15; req1 is granted on the clear_done cycle.
- Second clear_req mid-sweep at counter=7 → sweep still ends after addr 15; exactly one clear_done.
- req0 addr=20 → req0_ready=1; next cycle ram_we=0 and addr_err=1.
- rst_n low at counter=9 during a clear → all outputs 0 immediately; after release the block is in IDLE, no clear_done, and req0 is granted normally.
